sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// 2:1 arbiter sharing one sram-like port between instruction fetch (m0) and data (m1).
// m1 has fixed priority; a starvation counter forces m0 through, and an order FIFO routes completions.
module sram_like_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic        err
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [DEPTH-1:0] r_ids;
    logic             r_lock;
    logic             r_lock_id;
    logic [SW-1:0]    r_starve;
    logic             r_err;

    logic w_full;
    logic w_empty;
    logic w_grant;
    logic w_greq;
    logic w_push;
    logic w_pop;
    logic w_head;

    always_comb begin
        w_full  = (r_count == FULL_CNT);
        w_empty = (r_count == '0);
        // 1 selects m1; a held (locked) request keeps its master until accepted
        if (r_lock)
            w_grant = r_lock_id;
        else if (m0_req && (r_starve == STARVE_LIM))
            w_grant = 1'b0;
        else
            w_grant = m1_req;
        w_greq = w_grant ? m1_req : m0_req;
        s_req  = w_greq & ~w_full;

        s_wr    = 1'b0;
        s_size  = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (w_greq) begin
            s_wr    = w_grant ? m1_wr    : m0_wr;
            s_size  = w_grant ? m1_size  : m0_size;
            s_addr  = w_grant ? m1_addr  : m0_addr;
            s_wdata = w_grant ? m1_wdata : m0_wdata;
        end

        w_push = s_req & s_addr_ok;
        w_pop  = s_data_ok & ~w_empty;
        w_head = r_ids[r_rptr];

        m0_addr_ok = w_push & ~w_grant;
        m1_addr_ok = w_push &  w_grant;
        m0_data_ok = w_pop  & ~w_head;
        m1_data_ok = w_pop  &  w_head;
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
        err        = r_err;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_ids     <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_starve  <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_ids[r_wptr] <= w_grant;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);

            if (r_lock && !w_greq) begin
                r_lock <= 1'b0;
                r_err  <= 1'b1;
            end else if (w_push) begin
                r_lock <= 1'b0;
            end else if (s_req) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_grant;
            end

            if (s_data_ok && w_empty)
                r_err <= 1'b1;

            if (!m0_req || m0_addr_ok)
                r_starve <= '0;
            else if (r_starve != STARVE_LIM)
                r_starve <= r_starve + SW'(1);
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: arbitration, starvation, lock, FIFO ordering/full/wrap, error and reset.
module tb_sram_like_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_addr_ok, s_data_ok;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    sram_like_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_wr = 1'b0; m0_size = 2'd0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_size = 2'd0; m1_addr = '0; m1_wdata = '0;
        s_rdata = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        #2;
        chk("rst_s_req", {31'd0, s_req}, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_count", 32'(dut.r_count), 32'd0);
        chk("rst_dok", {30'd0, m0_data_ok, m1_data_ok}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Starvation: m1 wins 8 cycles, m0 forced on the 9th, m1 again on the 10th
        m0_req = 1'b1; m0_addr = 32'h100; m0_size = 2'd1;
        m1_req = 1'b1; m1_addr = 32'h200; m1_size = 2'd2;
        s_addr_ok = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk($sformatf("starve_addr_c%0d", i), s_addr, (i == 9) ? 32'h100 : 32'h200);
            chk($sformatf("starve_m0ok_c%0d", i), {31'd0, m0_addr_ok}, (i == 9) ? 32'd1 : 32'd0);
            if (i == 9) chk("starve_size_m0", {30'd0, s_size}, 32'd1);
            tick();
            s_data_ok = 1'b1;
        end
        m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0;
        #1;
        chk("starve_drain_m1dok", {31'd0, m1_data_ok}, 32'd1);
        tick();
        s_data_ok = 1'b0;
        #1;
        chk("starve_count0", 32'(dut.r_count), 32'd0);
        chk("starve_err0", {31'd0, err}, 32'd0);

        // Lock: m0 read held while s_addr_ok low; m1 arriving later cannot steal the port
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h1FC0_0000; m1_addr = 32'h300;
        #1;
        chk("lock_c1_addr", s_addr, 32'h1FC0_0000);
        tick();
        m1_req = 1'b1;
        #1;
        chk("lock_c2_addr", s_addr, 32'h1FC0_0000);
        chk("lock_c2_m1ok", {31'd0, m1_addr_ok}, 32'd0);
        tick();
        #1;
        chk("lock_c3_addr", s_addr, 32'h1FC0_0000);
        tick();
        s_addr_ok = 1'b1;
        #1;
        chk("lock_c4_addr", s_addr, 32'h1FC0_0000);
        chk("lock_c4_m0ok", {31'd0, m0_addr_ok}, 32'd1);
        tick();
        s_addr_ok = 1'b0;
        #1;
        chk("lock_c5_m1_addr", s_addr, 32'h300);
        m0_req = 1'b0; m1_req = 1'b0;
        s_data_ok = 1'b1; s_rdata = 32'hAA;
        #1;
        chk("lock_drain_m0dok", {31'd0, m0_data_ok}, 32'd1);
        chk("lock_drain_rdata", m0_rdata, 32'hAA);
        tick();
        s_data_ok = 1'b0;

        // Full: four m1 reads outstanding block the fifth until one completes
        m1_req = 1'b1; m1_addr = 32'h400; s_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("full_accept%0d", i), {31'd0, m1_addr_ok}, 32'd1);
            tick();
        end
        #1;
        chk("full_s_req", {31'd0, s_req}, 32'd0);
        chk("full_m1ok", {31'd0, m1_addr_ok}, 32'd0);
        chk("full_count", 32'(dut.r_count), 32'd4);
        tick();
        s_data_ok = 1'b1; s_rdata = 32'h55;
        #1;
        chk("full_pop_m1dok", {31'd0, m1_data_ok}, 32'd1);
        chk("full_pop_rdata", m1_rdata, 32'h55);
        tick();
        s_data_ok = 1'b0;
        #1;
        chk("full_resume_s_req", {31'd0, s_req}, 32'd1);
        chk("full_resume_m1ok", {31'd0, m1_addr_ok}, 32'd1);
        tick();
        m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("full_drain%0d", i), {31'd0, m1_data_ok}, 32'd1);
            tick();
        end
        s_data_ok = 1'b0;
        #1;
        chk("full_count0", 32'(dut.r_count), 32'd0);

        // Ordering: accept m0, m1 (write), m0; completions return in that order
        s_addr_ok = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h500;
        tick();
        m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b1; m1_wdata = 32'hDEAD_BEEF;
        #1;
        chk("ord_s_wr", {31'd0, s_wr}, 32'd1);
        chk("ord_s_wdata", s_wdata, 32'hDEAD_BEEF);
        tick();
        m1_req = 1'b0; m1_wr = 1'b0; m0_req = 1'b1;
        tick();
        m0_req = 1'b0; s_addr_ok = 1'b0;
        s_data_ok = 1'b1; s_rdata = 32'h11;
        #1;
        chk("ord1_dok", {30'd0, m0_data_ok, m1_data_ok}, 32'b10);
        chk("ord1_rdata", m0_rdata, 32'h11);
        tick();
        s_rdata = 32'h22;
        #1;
        chk("ord2_dok", {30'd0, m0_data_ok, m1_data_ok}, 32'b01);
        chk("ord2_rdata", m1_rdata, 32'h22);
        tick();
        s_rdata = 32'h33;
        #1;
        chk("ord3_dok", {30'd0, m0_data_ok, m1_data_ok}, 32'b10);
        chk("ord3_rdata", m0_rdata, 32'h33);
        tick();
        s_data_ok = 1'b0;
        #1;
        chk("ord_err0", {31'd0, err}, 32'd0);
        chk("ord_wptr", 32'(dut.r_wptr), 32'd3);

        // Wrap: fill to 3 entries from slot 3, then two push+pop cycles wrap each pointer
        m1_req = 1'b1; s_addr_ok = 1'b1;
        tick(); tick(); tick();
        chk("wrap_pre_count", 32'(dut.r_count), 32'd3);
        chk("wrap_pre_wptr", 32'(dut.r_wptr), 32'd2);
        chk("wrap_pre_rptr", 32'(dut.r_rptr), 32'd3);
        s_data_ok = 1'b1;
        tick();
        chk("wrap1_count", 32'(dut.r_count), 32'd3);
        chk("wrap1_rptr", 32'(dut.r_rptr), 32'd0);
        chk("wrap1_wptr", 32'(dut.r_wptr), 32'd3);
        tick();
        chk("wrap2_count", 32'(dut.r_count), 32'd3);
        chk("wrap2_wptr", 32'(dut.r_wptr), 32'd0);
        chk("wrap2_rptr", 32'(dut.r_rptr), 32'd1);
        m1_req = 1'b0; s_addr_ok = 1'b0;
        tick(); tick(); tick();
        s_data_ok = 1'b0;
        #1;
        chk("wrap_count0", 32'(dut.r_count), 32'd0);

        // Spurious completion on an empty FIFO, then asynchronous reset mid-transaction
        s_data_ok = 1'b1;
        #1;
        chk("empty_dok", {30'd0, m0_data_ok, m1_data_ok}, 32'd0);
        tick();
        s_data_ok = 1'b0;
        tick();
        chk("empty_err_held", {31'd0, err}, 32'd1);
        m1_req = 1'b1; s_addr_ok = 1'b1;
        tick(); tick();
        m1_req = 1'b0; s_addr_ok = 1'b0;
        chk("pre_rst_count", 32'(dut.r_count), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_err", {31'd0, err}, 32'd0);
        chk("async_rst_count", 32'(dut.r_count), 32'd0);
        resetn = 1'b1;
        tick();
        s_data_ok = 1'b1;
        #1;
        chk("post_rst_dok", {30'd0, m0_data_ok, m1_data_ok}, 32'd0);
        tick();
        s_data_ok = 1'b0;
        chk("post_rst_err", {31'd0, err}, 32'd1);

        // Locked master withdrawing its request raises err and releases the lock
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        tick();
        m0_req = 1'b1; m0_addr = 32'h600; m1_addr = 32'h700;
        tick();
        m0_req = 1'b0; m1_req = 1'b1;
        #1;
        chk("drop_s_req", {31'd0, s_req}, 32'd0);
        tick();
        chk("drop_err", {31'd0, err}, 32'd1);
        chk("drop_m1_addr", s_addr, 32'h700);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
